// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: status codes, NOP opcode and field values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: STAT_* codes, INOP, RNONE, hdr_t (narrow instruction fields), NOP_HDR.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'h1;
    localparam logic [2:0] STAT_HLT = 3'h2;
    localparam logic [2:0] STAT_ADR = 3'h3;
    localparam logic [2:0] STAT_INS = 3'h4;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    // Narrow instruction fields travel together; the WORD_W-wide valC/valP
    // stay separate because a package struct cannot take a parameter.
    typedef struct packed {
        logic [2:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] ra;
        logic [3:0] rb;
    } hdr_t;

    localparam hdr_t NOP_HDR = '{
        stat  : STAT_AOK,
        icode : INOP,
        ifun  : 4'h0,
        ra    : RNONE,
        rb    : RNONE
    };

endpackage

// File: rtl/pipe_reg_if.sv
// Bundle of the pipeline-register data, control and status signals.
// Latency: n/a (wires only).
// Backpressure: stall from the master holds every stage of the slave.
// Modports: master drives in_*/stall/bubble, slave drives out_*/ctl_conflict.
// With PIPE_REG_PERF_EN defined the slave also drives stall_cnt/bubble_cnt.
interface pipe_reg_if #(
    parameter int WORD_W = 64
);
    logic [2:0]        in_stat;
    logic [3:0]        in_icode;
    logic [3:0]        in_ifun;
    logic [3:0]        in_rA;
    logic [3:0]        in_rB;
    logic [WORD_W-1:0] in_valC;
    logic [WORD_W-1:0] in_valP;
    logic              stall;
    logic              bubble;

    logic [2:0]        out_stat;
    logic [3:0]        out_icode;
    logic [3:0]        out_ifun;
    logic [3:0]        out_rA;
    logic [3:0]        out_rB;
    logic [WORD_W-1:0] out_valC;
    logic [WORD_W-1:0] out_valP;
    logic              ctl_conflict;
`ifdef PIPE_REG_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    modport master (
        output in_stat, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
        output stall, bubble,
        input  out_stat, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP,
        input  ctl_conflict
`ifdef PIPE_REG_PERF_EN
        , input stall_cnt, bubble_cnt
`endif
    );

    modport slave (
        input  in_stat, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
        input  stall, bubble,
        output out_stat, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP,
        output ctl_conflict
`ifdef PIPE_REG_PERF_EN
        , output stall_cnt, bubble_cnt
`endif
    );

endinterface

// File: rtl/pipe_reg_stage.sv
// One pipeline register stage: hold, load NOP, or load upstream data.
// Latency: 1 cycle from d_* to q_*.
// Backpressure: hold=1 freezes contents for the edge (takes priority over load_nop).
// Ports: clk, rst_n (async active-low, loads NOP), hold, load_nop, d_hdr/d_valc/d_valp in,
//        q_hdr/q_valc/q_valp out.
module pipe_reg_stage
    import y86_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              load_nop,
    input  hdr_t              d_hdr,
    input  logic [WORD_W-1:0] d_valc,
    input  logic [WORD_W-1:0] d_valp,
    output hdr_t              q_hdr,
    output logic [WORD_W-1:0] q_valc,
    output logic [WORD_W-1:0] q_valp
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_hdr  <= NOP_HDR;
            q_valc <= '0;
            q_valp <= '0;
        end else if (hold) begin
            q_hdr  <= q_hdr;
            q_valc <= q_valc;
            q_valp <= q_valp;
        end else if (load_nop) begin
            q_hdr  <= NOP_HDR;
            q_valc <= '0;
            q_valp <= '0;
        end else begin
            q_hdr  <= d_hdr;
            q_valc <= d_valc;
            q_valp <= d_valp;
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Y86 inter-stage pipeline register, DEPTH (1..4) stages deep, with stall/bubble control.
// Latency: DEPTH cycles from in_* to out_* when neither stall nor bubble is applied.
// Backpressure: stall holds every stage; bubble (without stall) injects a NOP into stage 0.
// Ports: clk, rst_n (async active-low, all stages to NOP), bus (pipe_reg_if.slave).
// Optional: PIPE_REG_PERF_EN adds saturating 32-bit stall_cnt / bubble_cnt on the bus.
module pipe_reg
    import y86_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_reg_if.slave bus
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_reg: DEPTH must be in 1..4");
        end
    endgenerate

    hdr_t              in_hdr;
    logic              load_nop;
    logic              conflict_q;
    hdr_t              st_hdr  [DEPTH];
    logic [WORD_W-1:0] st_valc [DEPTH];
    logic [WORD_W-1:0] st_valp [DEPTH];

    assign in_hdr = '{
        stat  : bus.in_stat,
        icode : bus.in_icode,
        ifun  : bus.in_ifun,
        ra    : bus.in_rA,
        rb    : bus.in_rB
    };

    // Stall wins over bubble: a held stage 0 must not be overwritten by a NOP.
    assign load_nop = bus.bubble & ~bus.stall;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                pipe_reg_stage #(.WORD_W(WORD_W)) u_stage (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .hold     (bus.stall),
                    .load_nop (load_nop),
                    .d_hdr    (in_hdr),
                    .d_valc   (bus.in_valC),
                    .d_valp   (bus.in_valP),
                    .q_hdr    (st_hdr[g]),
                    .q_valc   (st_valc[g]),
                    .q_valp   (st_valp[g])
                );
            end else begin : g_body
                pipe_reg_stage #(.WORD_W(WORD_W)) u_stage (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .hold     (bus.stall),
                    .load_nop (1'b0),
                    .d_hdr    (st_hdr[g-1]),
                    .d_valc   (st_valc[g-1]),
                    .d_valp   (st_valp[g-1]),
                    .q_hdr    (st_hdr[g]),
                    .q_valc   (st_valc[g]),
                    .q_valp   (st_valp[g])
                );
            end
        end
    endgenerate

    assign bus.out_stat  = st_hdr[DEPTH-1].stat;
    assign bus.out_icode = st_hdr[DEPTH-1].icode;
    assign bus.out_ifun  = st_hdr[DEPTH-1].ifun;
    assign bus.out_rA    = st_hdr[DEPTH-1].ra;
    assign bus.out_rB    = st_hdr[DEPTH-1].rb;
    assign bus.out_valC  = st_valc[DEPTH-1];
    assign bus.out_valP  = st_valp[DEPTH-1];

    // Sticky: a simultaneous stall+bubble indicates a hazard-unit bug upstream,
    // so it is latched until reset for software to find.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else if (bus.stall && bus.bubble) begin
            conflict_q <= 1'b1;
        end
    end

    assign bus.ctl_conflict = conflict_q;

`ifdef PIPE_REG_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // A combined stall+bubble edge counts as a stall only, matching what the
    // stages actually did on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (bus.stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (load_nop && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg at DEPTH 1, 2 and 3 driven in lockstep.
// Latency: reference is a queue per DUT (front = newest entry, back = output).
// Backpressure: stall/bubble directed and randomized; PIPE_REG_PERF_EN checks counters.
module tb_pipe_reg;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } rec_t;

    localparam rec_t NOP = '{3'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_reg_if #(.WORD_W(64)) if_d1 ();
    pipe_reg_if #(.WORD_W(64)) if_d2 ();
    pipe_reg_if #(.WORD_W(64)) if_d3 ();

    pipe_reg #(.WORD_W(64), .DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if_d1));
    pipe_reg #(.WORD_W(64), .DEPTH(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if_d2));
    pipe_reg #(.WORD_W(64), .DEPTH(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(if_d3));

    rec_t mq [3][$];
    bit   mconf;
    int   checks = 0;
    int   passes = 0;
    logic [31:0] scnt, bcnt;

    function automatic rec_t got(input int k);
        rec_t r;
        case (k)
            0:       r = '{if_d1.out_stat, if_d1.out_icode, if_d1.out_ifun, if_d1.out_rA,
                           if_d1.out_rB, if_d1.out_valC, if_d1.out_valP};
            1:       r = '{if_d2.out_stat, if_d2.out_icode, if_d2.out_ifun, if_d2.out_rA,
                           if_d2.out_rB, if_d2.out_valC, if_d2.out_valP};
            default: r = '{if_d3.out_stat, if_d3.out_icode, if_d3.out_ifun, if_d3.out_rA,
                           if_d3.out_rB, if_d3.out_valC, if_d3.out_valP};
        endcase
        return r;
    endfunction

    function automatic logic got_conf(input int k);
        case (k)
            0:       return if_d1.ctl_conflict;
            1:       return if_d2.ctl_conflict;
            default: return if_d3.ctl_conflict;
        endcase
    endfunction

    task automatic set_inputs(input rec_t v, input bit s, input bit b);
        {if_d1.in_stat, if_d1.in_icode, if_d1.in_ifun, if_d1.in_rA, if_d1.in_rB,
         if_d1.in_valC, if_d1.in_valP} = v;
        {if_d2.in_stat, if_d2.in_icode, if_d2.in_ifun, if_d2.in_rA, if_d2.in_rB,
         if_d2.in_valC, if_d2.in_valP} = v;
        {if_d3.in_stat, if_d3.in_icode, if_d3.in_ifun, if_d3.in_rA, if_d3.in_rB,
         if_d3.in_valC, if_d3.in_valP} = v;
        if_d1.stall = s; if_d2.stall = s; if_d3.stall = s;
        if_d1.bubble = b; if_d2.bubble = b; if_d3.bubble = b;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            repeat (k + 1) mq[k].push_back(NOP);
        end
        mconf = 1'b0;
        scnt  = '0;
        bcnt  = '0;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            assert ({got(k), got_conf(k)} === {mq[k][$], mconf}) passes++;
            else $error("FAIL %s d%0d: observed %h/%0b expected %h/%0b",
                        tag, k + 1, got(k), got_conf(k), mq[k][$], mconf);
        end
`ifdef PIPE_REG_PERF_EN
        checks++;
        assert ({if_d1.stall_cnt, if_d1.bubble_cnt} === {scnt, bcnt}) passes++;
        else $error("FAIL %s perf: observed %0d/%0d expected %0d/%0d",
                    tag, if_d1.stall_cnt, if_d1.bubble_cnt, scnt, bcnt);
`endif
    endtask

    // Apply one cycle of stimulus, advance the reference at the edge, check at the falling edge.
    task automatic step(input rec_t v, input bit s, input bit b, input string tag);
        set_inputs(v, s, b);
        #1;
        check_all({tag, "_pre"});
        @(posedge clk);
        if (s) begin
            if (b) mconf = 1'b1;
            if (scnt != 32'hFFFF_FFFF) scnt = scnt + 1;
        end else begin
            if (b && bcnt != 32'hFFFF_FFFF) bcnt = bcnt + 1;
            for (int k = 0; k < 3; k++) begin
                mq[k].push_front(b ? NOP : v);
                void'(mq[k].pop_back());
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        checks++;
        assert ({if_d3.out_icode, if_d3.out_rA, if_d3.out_stat} === {4'h1, 4'hF, 3'h1}) passes++;
        else $error("FAIL %s_async: observed %h/%h/%h expected 1/f/1", tag,
                    if_d3.out_icode, if_d3.out_rA, if_d3.out_stat);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.stat  = 3'($urandom_range(0, 7));
        r.icode = 4'($urandom_range(0, 15));
        r.ifun  = 4'($urandom_range(0, 15));
        r.ra    = 4'($urandom_range(0, 15));
        r.rb    = 4'($urandom_range(0, 15));
        r.valc  = {$urandom, $urandom};
        r.valp  = {$urandom, $urandom};
        return r;
    endfunction

    initial begin
        rec_t v;
        rst_n = 1'b1;
        set_inputs(NOP, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter scenario: 5 stalls, 2 bubbles, 1 combined edge.
        repeat (5) step(rand_rec(), 1'b1, 1'b0, "stall5");
        repeat (2) step(rand_rec(), 1'b0, 1'b1, "bubble2");
        step(rand_rec(), 1'b1, 1'b1, "combined");
`ifdef PIPE_REG_PERF_EN
        checks++;
        assert ({if_d1.stall_cnt, if_d1.bubble_cnt} === {32'd6, 32'd2}) passes++;
        else $error("FAIL perf_fixed: observed %0d/%0d expected 6/2",
                    if_d1.stall_cnt, if_d1.bubble_cnt);
`endif
        // Conflict flag stays set with both controls low.
        repeat (3) step(rand_rec(), 1'b0, 1'b0, "sticky");
        checks++;
        assert (if_d2.ctl_conflict === 1'b1) passes++;
        else $error("FAIL sticky_conf: observed %0b expected 1", if_d2.ctl_conflict);
        mid_reset("conf_reset");

        // Single instruction through DEPTH=3: appears exactly 3 edges later.
        v = NOP; v.icode = 4'h6; v.valc = 64'h10;
        step(v, 1'b0, 1'b0, "lat_inj");
        step(NOP, 1'b0, 1'b0, "lat_1");
        step(NOP, 1'b0, 1'b0, "lat_2");
        checks++;
        assert ({if_d3.out_icode, if_d3.out_valC} === {4'h6, 64'h10}) passes++;
        else $error("FAIL lat3: observed %h/%h expected 6/10", if_d3.out_icode, if_d3.out_valC);
        step(NOP, 1'b0, 1'b0, "lat_3");

        // DEPTH=1 hold under stall while valP changes.
        v = rand_rec(); v.valp = 64'h20;
        step(v, 1'b0, 1'b0, "hold_load");
        repeat (4) step(rand_rec(), 1'b1, 1'b0, "hold");
        checks++;
        assert (if_d1.out_valP === 64'h20) passes++;
        else $error("FAIL hold_valp: observed %h expected 20", if_d1.out_valP);
        v = rand_rec(); v.valp = 64'h99;
        step(v, 1'b0, 1'b0, "hold_release");
        checks++;
        assert (if_d1.out_valP === 64'h99) passes++;
        else $error("FAIL release_valp: observed %h expected 99", if_d1.out_valP);

        // Bubble while icode=3 is presented.
        v = rand_rec(); v.icode = 4'h7;
        step(v, 1'b0, 1'b0, "bub_pre");
        v = rand_rec(); v.icode = 4'h3;
        step(v, 1'b0, 1'b1, "bub");
        step(rand_rec(), 1'b0, 1'b0, "bub_1");
        checks++;
        assert (if_d2.out_icode === 4'h1) passes++;
        else $error("FAIL bub_nop: observed %h expected 1", if_d2.out_icode);

        // Reset in the middle of a stall discards held data.
        repeat (3) step(rand_rec(), 1'b0, 1'b0, "fill");
        step(rand_rec(), 1'b1, 1'b0, "stall_hold");
        set_inputs(rand_rec(), 1'b1, 1'b0);
        mid_reset("stall_reset");

        // Random traffic including HLT/ADR/INS status codes.
        for (int i = 0; i < 300; i++) begin
            step(rand_rec(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
